// File: rtl/hs4_pkg.sv
// Shared constants and state encoding for the 4-phase requester.
`timescale 1ns/1ps
package hs4_pkg;

  localparam int DEF_DATA_W      = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TIMEOUT_CYC = 255;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_REL  = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } hs4_state_e;

  // Width of a counter that must be able to hold the value max_val.
  function automatic int cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/hs_sync2.sv
// Multi-flop synchronizer for a single asynchronous level; depth set by STAGES.
`timescale 1ns/1ps
module hs_sync2 #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], d};
    end
  end

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/hs4_requester.sv
// Synchronous-side requester of a 4-phase bundled-data handshake.
// Optional per-phase timeout with sticky err is enabled by defining HS4_TIMEOUT_EN.
`timescale 1ns/1ps
module hs4_requester
  import hs4_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              rdy,
  output logic              req_out,
  output logic [DATA_W-1:0] data_out,
  input  logic              ack_in,
  output logic              done,
  output logic              err,
  input  logic              err_clr
);

  hs4_state_e        state_reg, state_next;
  logic              req_reg, req_next;
  logic              done_reg, done_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic [SYNC_STAGES-1:0] settle_reg;
  logic              ack_s;
  logic              timeout;

  hs_sync2 #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ack_in),
    .q     (ack_s)
  );

  // Right after reset the synchronizer still holds zeros rather than the real
  // ack level; hold rdy low until every stage has sampled ack_in once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_reg <= '0;
    end else begin
      settle_reg <= {settle_reg[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rdy = (state_reg == ST_IDLE) && !ack_s && settle_reg[SYNC_STAGES-1];

`ifdef HS4_TIMEOUT_EN
  localparam int CNT_W = cnt_width(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             err_reg;

  // Counter restarts on every phase change, so it measures the current phase only.
  always_comb begin
    cnt_next = '0;
    if (((state_reg == ST_REQ) || (state_reg == ST_REL)) && (state_next == state_reg)) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  assign timeout = (cnt_reg == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      err_reg <= (state_next == ST_ERR);
    end
  end

  assign err = err_reg;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      req_reg   <= 1'b0;
      done_reg  <= 1'b0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      req_reg   <= req_next;
      done_reg  <= done_next;
      data_reg  <= data_next;
    end
  end

  // An ack edge always wins over a coincident timeout.
  always_comb begin
    state_next = state_reg;
    req_next   = req_reg;
    done_next  = 1'b0;
    data_next  = data_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start && rdy) begin
          state_next = ST_REQ;
          req_next   = 1'b1;
          data_next  = data_in;
        end
      end
      ST_REQ: begin
        if (ack_s) begin
          state_next = ST_REL;
          req_next   = 1'b0;
        end else if (timeout) begin
          state_next = ST_ERR;
          req_next   = 1'b0;
        end
      end
      ST_REL: begin
        if (!ack_s) begin
          state_next = ST_DONE;
          done_next  = 1'b1;
        end else if (timeout) begin
          state_next = ST_ERR;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      ST_ERR: begin
        if (err_clr) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        req_next   = 1'b0;
      end
    endcase
  end

  assign req_out  = req_reg;
  assign done     = done_reg;
  assign data_out = data_reg;

endmodule

// File: tb/tb_hs4_requester.sv
// Self-checking bench for hs4_requester: directed handshake timing plus a long
// randomized run against an asynchronous 4-phase peer model.
`timescale 1ns/1ps
module tb_hs4_requester;

  localparam int DW    = 8;
  localparam int SS    = 2;
  localparam int TO    = 16;
  localparam int CLK_P = 10;
  localparam int NXFER = 1000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          ack_in = 1'b0;
  logic          err_clr = 1'b0;
  logic          rdy, req_out, done, err;
  logic [DW-1:0] data_out;

  int n_checks = 0;
  int n_fail   = 0;

  bit peer_en   = 1'b0;
  bit peer_rand = 1'b0;

  hs4_requester #(
    .DATA_W      (DW),
    .SYNC_STAGES (SS),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .data_in  (data_in),
    .rdy      (rdy),
    .req_out  (req_out),
    .data_out (data_out),
    .ack_in   (ack_in),
    .done     (done),
    .err      (err),
    .err_clr  (err_clr)
  );

  always #(CLK_P/2) clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous 4-phase peer: ack follows req after a fixed or random delay.
  initial begin
    forever begin
      wait (peer_en && (ack_in != req_out));
      if (peer_rand) #($urandom_range(2, 4*CLK_P));
      else           #(3*CLK_P + 1);
      if (peer_en) ack_in = req_out;
    end
  end

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fall_c, done_c, ndone, bad_data, err_c, second_rise, accepts, dones, rise_cyc;
    int rise_q[$];
    logic [DW-1:0] drv, cur_data;
    logic prev_req, prev_done, in_flight, st;

    // ---------------- reset state ----------------
    #3;
    check("rst_req", req_out, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_data", data_out, 0);
    #20 rst_n = 1'b1;
    repeat (SS + 2) step();
    check("rdy_after_reset", rdy, 1);

    // ---------------- basic transfer ----------------
    peer_en = 1'b1; peer_rand = 1'b0;
    data_in = 8'hA5; start = 1'b1;
    step();
    start = 1'b0; data_in = 8'h00;
    check("basic_req_rise", req_out, 1);
    check("basic_capture", data_out, 8'hA5);
    fall_c = -1; done_c = -1; ndone = 0; bad_data = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (req_out && data_out !== 8'hA5) bad_data++;
      if (!req_out && fall_c < 0) fall_c = c;
      if (done) begin
        ndone++;
        if (done_c < 0) done_c = c;
      end
    end
    // ack 3 cycles after req, SS sync flops, one FSM edge; release mirrors it
    check("basic_req_fall_cycle", fall_c, 3 + SS + 1);
    check("basic_done_cycle", done_c, 2*(3 + SS + 1));
    check("basic_done_count", ndone, 1);
    check("basic_data_stable", bad_data, 0);
    check("basic_rdy_back", rdy, 1);
    check("basic_data_hold", data_out, 8'hA5);

    // ---------------- back-to-back with start held ----------------
    rise_q.delete();
    ndone = 0; prev_req = 1'b0;
    start = 1'b1;
    for (int c = 0; c < 80 && ndone < 2; c++) begin
      drv = DW'($urandom);
      data_in = drv;
      step();
      if (req_out && !prev_req) begin
        rise_q.push_back(c);
        check("b2b_capture", data_out, drv);
      end
      if (done) ndone++;
      prev_req = req_out;
    end
    start = 1'b0;
    second_rise = (rise_q.size() >= 2) ? rise_q[1] : -1;
    check("b2b_done_count", ndone, 2);
    check("b2b_accept_count", rise_q.size(), 2);
    check("b2b_second_start", second_rise, 2*(3 + SS + 1) + 2);
    step();

    // ---------------- peer never acks ----------------
    peer_en = 1'b0;
    data_in = DW'($urandom); start = 1'b1;
    step();
    start = 1'b0;
    check("to_req_rise", req_out, 1);
`ifdef HS4_TIMEOUT_EN
    err_c = -1;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (err && err_c < 0) err_c = c;
    end
    check("to_err_cycle", err_c, TO);
    check("to_err_sticky", err, 1);
    check("to_req_dropped", req_out, 0);
    check("to_rdy_in_err", rdy, 0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("to_err_cleared", err, 0);
    check("to_rdy_after_clr", rdy, 1);
`else
    err_c = 0;
    repeat (40) step();
    check("noto_err", err, 0);
    check("noto_req_waits", req_out, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("noto_clr_ignored", req_out, 1);
    peer_en = 1'b1;
    for (int c = 0; c < 60 && err_c == 0; c++) begin
      step();
      if (done) err_c = 1;
    end
    check("noto_late_done", err_c, 1);
    step();
`endif

    // ---------------- reset mid-REQ with ack held ----------------
    peer_en = 1'b0;
    step();
    data_in = DW'($urandom); start = 1'b1;
    step();
    start = 1'b0;
    check("rst_mid_req_up", req_out, 1);
    ack_in = 1'b1;
    step();
    check("rst_mid_req_before", req_out, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_req_drop", req_out, 0);
    check("rst_mid_data_clr", data_out, 0);
    check("rst_mid_done", done, 0);
    #(2*CLK_P) rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      check("rst_stale_ack_rdy", rdy, 0);
    end
    ack_in = 1'b0;
    repeat (SS - 1) step();
    check("rst_rdy_still_low", rdy, 0);
    step();
    check("rst_rdy_after_sync", rdy, 1);

    // ---------------- randomized async peer ----------------
    peer_en = 1'b1; peer_rand = 1'b1;
    accepts = 0; dones = 0; in_flight = 1'b0; rise_cyc = 0;
    prev_req = req_out; prev_done = done; cur_data = data_out;
    for (int c = 0; c < 60000 && dones < NXFER; c++) begin
      st = (accepts < NXFER) && ($urandom_range(0, 3) == 0);
      start = st;
      drv = DW'($urandom);
      data_in = drv;
      step();
      if (req_out && !prev_req) begin
        accepts++;
        check("rnd_accept_idle", in_flight, 0);
        check("rnd_accept_start", st, 1);
        check("rnd_rise_ack_low", ack_in, 0);
        check("rnd_capture", data_out, drv);
        cur_data = drv;
        in_flight = 1'b1;
        rise_cyc = c;
      end else if (req_out) begin
        check("rnd_data_stable", data_out, cur_data);
      end
      if (!req_out && prev_req) begin
        check("rnd_fall_ack_high", ack_in, 1);
        check("rnd_min_handshake", (c - rise_cyc) >= SS + 1, 1);
      end
      if (done) begin
        dones++;
        check("rnd_done_in_flight", in_flight, 1);
        check("rnd_done_single", prev_done, 0);
        in_flight = 1'b0;
      end
      prev_req = req_out;
      prev_done = done;
    end
    start = 1'b0;
    check("rnd_accepts", accepts, NXFER);
    check("rnd_dones", dones, accepts);
    check("rnd_err", err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
